// File: rtl/i2cs_reg_arbiter.sv
// Register RAM arbiter: one single-port RAM shared by the I2C register port (posted writes,
// auto-incrementing pointer, coherent read shadow) and an APB slave, one access per cycle.
module i2cs_reg_arbiter #(
  parameter int AW           = 5,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    i2c_reg_addr_i,
  input  logic [7:0]    i2c_reg_wdata_i,
  input  logic          i2c_reg_wrenable_i,
  input  logic          i2c_rd_byte_done_i,
  output logic [7:0]    i2c_reg_rddata_o,
  input  logic          apb_req_i,
  input  logic          apb_we_i,
  input  logic [AW-1:0] apb_addr_i,
  input  logic [7:0]    apb_wdata_i,
  output logic          apb_ready_o,
  output logic [7:0]    apb_rdata_o,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [7:0]    mem_wdata_o,
  input  logic [7:0]    mem_rdata_i,
  output logic          wr_ovf_o
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic {ARB, RD} state_t;
  state_t state_q, state_d;

  logic [7:0]    addr_q;
  logic [AW-1:0] offset_q;
  logic [AW-1:0] ptr;
  logic          addr_chg;
  logic          wr_pend_q;
  logic [AW-1:0] wr_addr_q;
  logic [7:0]    wr_data_q;
  logic          ovf_q;
  logic          rf_pend_q;
  logic          init_q;
  logic [SW-1:0] starve_q;
  logic          rd_src_apb_q;
  logic [AW-1:0] rd_addr_q;
  logic          apb_rd_done_q;
  logic [7:0]    apb_rdata_q;
  logic [7:0]    shadow_q;
  logic          apb_vld;
  logic          gnt_wr, gnt_rf, gnt_apb;
  logic          rd_gnt, wr_hit, rf_fill;

  assign addr_chg = (i2c_reg_addr_i != addr_q);
  assign ptr      = i2c_reg_addr_i[AW-1:0] + offset_q;
  // An APB read is being completed this cycle; its request is still held, so hide it.
  assign apb_vld  = apb_req_i && !apb_rd_done_q;

  // NOTE: every signal driven here gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d     = ARB;
    gnt_wr      = 1'b0;
    gnt_rf      = 1'b0;
    gnt_apb     = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (!rst && state_q == ARB) begin
      if (apb_vld && starve_q == SW'(STARVE_LIMIT)) gnt_apb = 1'b1;
      else if (wr_pend_q)                           gnt_wr  = 1'b1;
      else if (rf_pend_q)                           gnt_rf  = 1'b1;
      else if (apb_vld)                             gnt_apb = 1'b1;
    end
    if (gnt_wr) begin
      mem_req_o   = 1'b1;
      mem_we_o    = 1'b1;
      mem_addr_o  = wr_addr_q;
      mem_wdata_o = wr_data_q;
    end
    if (gnt_rf) begin
      mem_req_o  = 1'b1;
      mem_addr_o = ptr;
      state_d    = RD;
    end
    if (gnt_apb) begin
      mem_req_o   = 1'b1;
      mem_we_o    = apb_we_i;
      mem_addr_o  = apb_addr_i;
      mem_wdata_o = apb_wdata_i;
      if (!apb_we_i) state_d = RD;
    end
  end

  assign rd_gnt  = gnt_rf || (gnt_apb && !apb_we_i);
  assign wr_hit  = mem_req_o && mem_we_o && (mem_addr_o == ptr);
  assign rf_fill = (state_q == RD) && !rd_src_apb_q && (rd_addr_q == ptr);

  assign apb_ready_o      = (gnt_apb && apb_we_i) || apb_rd_done_q;
  assign apb_rdata_o      = apb_rdata_q;
  assign i2c_reg_rddata_o = shadow_q;
  assign wr_ovf_o         = ovf_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ARB;
      addr_q        <= '0;
      offset_q      <= '0;
      wr_pend_q     <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      ovf_q         <= 1'b0;
      rf_pend_q     <= 1'b0;
      init_q        <= 1'b0;
      starve_q      <= '0;
      rd_src_apb_q  <= 1'b0;
      rd_addr_q     <= '0;
      apb_rd_done_q <= 1'b0;
      apb_rdata_q   <= '0;
      shadow_q      <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= i2c_reg_addr_i;
      init_q  <= 1'b1;

      if (addr_chg)                                     offset_q <= '0;
      else if (i2c_reg_wrenable_i || i2c_rd_byte_done_i) offset_q <= offset_q + 1'b1;

      // A drain in the same cycle frees the slot, so only an undrained entry overflows.
      if (i2c_reg_wrenable_i) begin
        wr_pend_q <= 1'b1;
        wr_addr_q <= ptr;
        wr_data_q <= i2c_reg_wdata_i;
        if (wr_pend_q && !gnt_wr) ovf_q <= 1'b1;
      end else if (gnt_wr) begin
        wr_pend_q <= 1'b0;
      end

      if (addr_chg || i2c_rd_byte_done_i || wr_hit || !init_q) rf_pend_q <= 1'b1;
      else if (rf_fill)                                        rf_pend_q <= 1'b0;

      if (gnt_apb || !apb_vld)  starve_q <= '0;
      else if (gnt_wr || gnt_rf) starve_q <= starve_q + 1'b1;

      if (rd_gnt) begin
        rd_src_apb_q <= gnt_apb;
        rd_addr_q    <= mem_addr_o;
      end

      apb_rd_done_q <= (state_q == RD) && rd_src_apb_q;
      if (state_q == RD && rd_src_apb_q) apb_rdata_q <= mem_rdata_i;
      if (rf_fill)                       shadow_q    <= mem_rdata_i;
    end
  end
endmodule
